csv_field_parser: RTL and testbench

CSV_FIELD_PARSER -- requirements
Module: csv_field_parser

---
 rtl/csv_pkg.sv | 16 +
 rtl/csv_dec_acc.sv | 22 ++
 rtl/csv_field_parser.sv | 141 ++++++++++++++
 tb/tb_csv_field_parser.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/csv_pkg.sv
// Shared ASCII constants and FSM state encoding for the CSV field parser.
package csv_pkg;

    localparam logic [7:0] CHR_COMMA = 8'h2C;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_9     = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_EMIT  = 2'd2
    } csv_state_e;

endpackage

// File: rtl/csv_dec_acc.sv
// Combinational decimal accumulate step: sum = acc*10 + digit, with overflow flag.
module csv_dec_acc #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    localparam int unsigned WW = W + 4;

    logic [WW-1:0] wide;

    // Extra four bits hold any carry past W so overflow is exact.
    always_comb begin
        wide  = WW'(acc_i) * WW'(10) + WW'(digit_i);
        sum_o = wide[W-1:0];
        ovf_o = |wide[WW-1:W];
    end

endmodule

// File: rtl/csv_field_parser.sv
// CSV field parser: pops ASCII bytes from a FIFO, accumulates unsigned decimal
// fields and emits one result per ',' or LF terminator.
// Optional feature: define CSV_PARSER_SAT_EN to saturate on overflow instead of
// wrapping and flagging an error.
module csv_field_parser
    import csv_pkg::*;
#(
    parameter int unsigned VAL_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fifo_rready,
    output logic                 fifo_rreq,
    input  logic [7:0]           fifo_rdata,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [VAL_WIDTH-1:0] o_value,
    output logic [IDX_WIDTH-1:0] o_field_idx,
    output logic                 o_eol,
    output logic                 o_err
);

    csv_state_e           state_q, state_d;
    logic [VAL_WIDTH-1:0] acc_q, acc_d;
    logic                 err_q, err_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 armed_q;

    logic                 valid_q, valid_d;
    logic [VAL_WIDTH-1:0] value_q, value_d;
    logic [IDX_WIDTH-1:0] oidx_q, oidx_d;
    logic                 eol_q, eol_d;
    logic                 oerr_q, oerr_d;

    logic [VAL_WIDTH-1:0] step_sum;
    logic                 step_ovf;
    logic                 is_digit;

    assign is_digit = (fifo_rdata >= CHR_0) && (fifo_rdata <= CHR_9);

    csv_dec_acc #(.W(VAL_WIDTH)) u_dec_acc (
        .acc_i   (acc_q),
        .digit_i (4'(fifo_rdata - CHR_0)),
        .sum_o   (step_sum),
        .ovf_o   (step_ovf)
    );

    // Next-state, datapath and pop-request logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        err_d     = err_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        value_d   = value_q;
        oidx_d    = oidx_q;
        eol_d     = eol_q;
        oerr_d    = oerr_q;
        fifo_rreq = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // armed_q keeps the pop request low during and right at reset release.
                fifo_rreq = fifo_rready & armed_q;
                if (fifo_rreq) begin
                    state_d = ST_PARSE;
                end
            end
            ST_PARSE: begin
                state_d = ST_IDLE;
                if (is_digit) begin
`ifdef CSV_PARSER_SAT_EN
                    // All-ones re-overflows on any later digit, so it sticks for the field.
                    acc_d = step_ovf ? {VAL_WIDTH{1'b1}} : step_sum;
`else
                    acc_d = step_sum;
                    if (step_ovf) begin
                        err_d = 1'b1;
                    end
`endif
                end else if (fifo_rdata == CHR_COMMA || fifo_rdata == CHR_LF) begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                    value_d = acc_q;
                    oidx_d  = idx_q;
                    eol_d   = (fifo_rdata == CHR_LF);
                    oerr_d  = err_q;
                end else if (fifo_rdata != CHR_CR) begin
                    err_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = eol_q ? '0 : idx_q + IDX_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
            oidx_q  <= '0;
            eol_q   <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            armed_q <= 1'b1;
            valid_q <= valid_d;
            value_q <= value_d;
            oidx_q  <= oidx_d;
            eol_q   <= eol_d;
            oerr_q  <= oerr_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_value     = value_q;
    assign o_field_idx = oidx_q;
    assign o_eol       = eol_q;
    assign o_err       = oerr_q;

endmodule

// File: tb/tb_csv_field_parser.sv
// Directed bench for csv_field_parser with a byte-FIFO model on the read side.
module tb_csv_field_parser;

    localparam int unsigned VW = 16;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          fifo_rready;
    logic          fifo_rreq;
    logic [7:0]    fifo_rdata = 8'h00;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [VW-1:0] o_value;
    logic [IW-1:0] o_field_idx;
    logic          o_eol;
    logic          o_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] fbuf [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    csv_field_parser #(.VAL_WIDTH(VW), .IDX_WIDTH(IW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .fifo_rready (fifo_rready),
        .fifo_rreq   (fifo_rreq),
        .fifo_rdata  (fifo_rdata),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_value     (o_value),
        .o_field_idx (o_field_idx),
        .o_eol       (o_eol),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    assign fifo_rready = (rd_ptr != wr_ptr);

    // FIFO model: a popped byte appears on fifo_rdata the following cycle.
    always @(posedge clk) begin
        if (fifo_rreq) begin
            fifo_rdata <= fbuf[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            fbuf[wr_ptr[7:0]] = s[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (o_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    endtask

    task automatic expect_field(input string tag, input int v, input int idx,
                                input bit eol, input bit err);
        wait_valid(tag);
        chk({tag, ".value"}, 32'(o_value), 32'(v));
        chk({tag, ".idx"},   32'(o_field_idx), 32'(idx));
        chk({tag, ".eol"},   32'(o_eol), 32'(eol));
        chk({tag, ".err"},   32'(o_err), 32'(err));
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({tag, ".drop"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.value", 32'(o_value), 32'd0);
        chk("rst.idx",   32'(o_field_idx), 32'd0);
        chk("rst.rreq",  32'(fifo_rreq), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Two-field record, then the next record restarts at index 0.
        push_str("12,345\n");
        expect_field("r1f0", 12, 0, 1'b0, 1'b0);
        expect_field("r1f1", 345, 1, 1'b1, 1'b0);

        // Overflow on the fifth digit of 70000.
        push_str("70000,\n");
`ifdef CSV_PARSER_SAT_EN
        expect_field("ovf", 65535, 0, 1'b0, 1'b0);
`else
        expect_field("ovf", 4464, 0, 1'b0, 1'b1);
`endif
        expect_field("ovf_eol", 0, 1, 1'b1, 1'b0);

        // Bad character sets the error; CR is ignored; empty field emits 0.
        push_str("1a2,\r\n");
        expect_field("bad", 12, 0, 1'b0, 1'b1);
        expect_field("crlf", 0, 1, 1'b1, 1'b0);

        // Backpressure: result holds and no pops while i_ready is low.
        push_str("7,\n");
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_valid", 32'(o_valid), 32'd1);
            chk("bp.hold_value", 32'(o_value), 32'd7);
            chk("bp.rready",     32'(fifo_rready), 32'd1);
            chk("bp.rreq",       32'(fifo_rreq), 32'd0);
            @(negedge clk);
        end
        expect_field("bp", 7, 0, 1'b0, 1'b0);
        expect_field("bp_eol", 0, 1, 1'b1, 1'b0);

        // Consecutive empty fields.
        push_str(",,\n");
        expect_field("empty0", 0, 0, 1'b0, 1'b0);
        expect_field("empty1", 0, 1, 1'b0, 1'b0);
        expect_field("empty2", 0, 2, 1'b1, 1'b0);

        // Reset mid-field discards partial "98" and restarts at index 0.
        push_str("3,98");
        expect_field("pre_rst", 3, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        push_str("5,");
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst.valid", 32'(o_valid), 32'd0);
            chk("mid_rst.value", 32'(o_value), 32'd0);
            chk("mid_rst.idx",   32'(o_field_idx), 32'd0);
            chk("mid_rst.eol",   32'(o_eol), 32'd0);
            chk("mid_rst.err",   32'(o_err), 32'd0);
            chk("mid_rst.rreq",  32'(fifo_rreq), 32'd0);
            @(negedge clk);
        end
        resetn = 1'b1;
        @(negedge clk);
        expect_field("post_rst", 5, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("post_rst.idle", 32'(o_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
